image_sequencer: RTL and testbench

IMAGE_SEQUENCER -- requirements
Module: image_sequencer

---
 rtl/cnn_seq_pkg.sv | 29 ++
 rtl/img_addr_gen.sv | 71 +++++++
 rtl/image_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_image_sequencer.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_seq_pkg.sv
// Shared constants and FSM encoding for the CNN image sequencer.
package cnn_seq_pkg;

    localparam int unsigned IMG_PIXELS_DEF = 784;
    localparam int unsigned MAX_IMAGES_DEF = 1000;
    localparam int unsigned TIMEOUT_DEF    = 4095;

    localparam int unsigned ADDR_W       = 20;
    localparam int unsigned IMG_IDX_W    = 10;
    localparam int unsigned PIX_W        = 8;
    localparam int unsigned LBL_W        = 4;
    localparam int unsigned FLUSH_CYCLES = 2;
    localparam int unsigned FLUSH_W      = 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FLUSH  = 3'd1,
        ST_STREAM = 3'd2,
        ST_WAIT   = 3'd3,
        ST_SCORE  = 3'd4,
        ST_DONE   = 3'd5
    } seq_state_e;

    // States during which a run is in progress and new starts are ignored.
    function automatic logic is_busy(input seq_state_e s);
        return (s == ST_FLUSH) || (s == ST_STREAM) || (s == ST_WAIT) || (s == ST_SCORE);
    endfunction

endpackage

// File: rtl/img_addr_gen.sv
// Pixel-store address generator: per-image base accumulator plus pixel counter.
module img_addr_gen
    import cnn_seq_pkg::*;
#(
    parameter int unsigned IMG_PIXELS = IMG_PIXELS_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              base_clr_i,
    input  logic              base_adv_i,
    input  logic              load_i,
    input  logic              issue_en_i,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic              issue_c_o,
    output logic              last_c_o
);

    localparam int unsigned IDX_W = (IMG_PIXELS > 1) ? $clog2(IMG_PIXELS) : 1;

    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              spent_q, spent_d;
    logic              is_last;

    assign is_last   = (idx_q == IDX_W'(IMG_PIXELS - 1));
    assign issue_c_o = issue_en_i && !spent_q;
    assign last_c_o  = issue_c_o && is_last;
    assign rd_addr_o = addr_q;

    // Next base/address/index; the base only ever grows by one image stride.
    always_comb begin
        base_d  = base_q;
        addr_d  = addr_q;
        idx_d   = idx_q;
        spent_d = spent_q;
        if (base_clr_i) begin
            base_d = '0;
        end else if (base_adv_i) begin
            base_d = base_q + ADDR_W'(IMG_PIXELS);
        end
        if (load_i) begin
            addr_d  = base_q;
            idx_d   = '0;
            spent_d = 1'b0;
        end else if (issue_c_o) begin
            if (is_last) begin
                spent_d = 1'b1;
            end else begin
                addr_d = addr_q + ADDR_W'(1);
                idx_d  = idx_q + IDX_W'(1);
            end
        end
    end

    // Address generator state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            base_q  <= '0;
            addr_q  <= '0;
            idx_q   <= '0;
            spent_q <= 1'b1;
        end else begin
            base_q  <= base_d;
            addr_q  <= addr_d;
            idx_q   <= idx_d;
            spent_q <= spent_d;
        end
    end

endmodule

// File: rtl/image_sequencer.sv
// Streams stored images into the CNN pipeline and scores its decisions against labels.
module image_sequencer
    import cnn_seq_pkg::*;
#(
    parameter int unsigned IMG_PIXELS = IMG_PIXELS_DEF,
    parameter int unsigned MAX_IMAGES = MAX_IMAGES_DEF,
    parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [IMG_IDX_W-1:0] num_images,
    output logic [ADDR_W-1:0]    rd_addr,
    input  logic [PIX_W-1:0]     rd_data,
    output logic [IMG_IDX_W-1:0] lbl_addr,
    input  logic [LBL_W-1:0]     lbl_data,
    output logic [PIX_W-1:0]     pix_out,
    output logic                 pix_valid,
    output logic                 pipe_rst_n,
    input  logic [LBL_W-1:0]     decision,
    input  logic                 decision_valid,
    output logic [IMG_IDX_W-1:0] hits,
    output logic [IMG_IDX_W-1:0] total,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout_err
);

    localparam int unsigned CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned CNT1_W = IMG_IDX_W + 1;

    seq_state_e           state_q, state_d;
    logic [FLUSH_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0]     wait_cnt_q, wait_cnt_d;
    logic [IMG_IDX_W-1:0] num_q, num_d;
    logic [IMG_IDX_W-1:0] img_idx_q, img_idx_d;
    logic [IMG_IDX_W-1:0] hits_q, hits_d;
    logic [IMG_IDX_W-1:0] total_q, total_d;
    logic [LBL_W-1:0]     label_q, label_d;
    logic [LBL_W-1:0]     dec_q, dec_d;
    logic                 miss_q, miss_d;
    logic                 tmo_q, tmo_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 pipe_q, pipe_d;

    logic                 rd_vld_q, rd_last_q;
    logic                 pix_vld_q, pix_last_q;
    logic [PIX_W-1:0]     pix_q;

    logic                 base_clr_c, base_adv_c, load_c, issue_en_c;
    logic                 issue_c, last_c;

    img_addr_gen #(
        .IMG_PIXELS (IMG_PIXELS)
    ) u_addr_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .base_clr_i (base_clr_c),
        .base_adv_i (base_adv_c),
        .load_i     (load_c),
        .issue_en_i (issue_en_c),
        .rd_addr_o  (rd_addr),
        .issue_c_o  (issue_c),
        .last_c_o   (last_c)
    );

    assign lbl_addr    = img_idx_q;
    assign pix_out     = pix_q;
    assign pix_valid   = pix_vld_q;
    assign pipe_rst_n  = pipe_q;
    assign hits        = hits_q;
    assign total       = total_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout_err = tmo_q;
    assign issue_en_c  = (state_q == ST_STREAM);

    // Next-state, scoring and registered-output decode.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = '0;
        wait_cnt_d  = '0;
        num_d       = num_q;
        img_idx_d   = img_idx_q;
        hits_d      = hits_q;
        total_d     = total_q;
        label_d     = label_q;
        dec_d       = dec_q;
        miss_d      = miss_q;
        tmo_d       = tmo_q;
        base_clr_c  = 1'b0;
        base_adv_c  = 1'b0;
        load_c      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if ((num_images != '0) && (32'(num_images) <= MAX_IMAGES)) begin
                        state_d    = ST_FLUSH;
                        num_d      = num_images;
                        img_idx_d  = '0;
                        hits_d     = '0;
                        total_d    = '0;
                        tmo_d      = 1'b0;
                        base_clr_c = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_FLUSH: begin
                load_c = 1'b1;
                miss_d = 1'b0;
                if (flush_cnt_q == FLUSH_W'(FLUSH_CYCLES - 1)) begin
                    state_d = ST_STREAM;
                end else begin
                    flush_cnt_d = flush_cnt_q + FLUSH_W'(1);
                end
            end
            ST_STREAM: begin
                label_d = lbl_data;
                if (pix_last_q) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (decision_valid) begin
                    dec_d   = decision;
                    miss_d  = 1'b0;
                    state_d = ST_SCORE;
                end else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    miss_d  = 1'b1;
                    tmo_d   = 1'b1;
                    state_d = ST_SCORE;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            ST_SCORE: begin
                base_adv_c = 1'b1;
                img_idx_d  = img_idx_q + IMG_IDX_W'(1);
                if (total_q < num_q) begin
                    total_d = total_q + IMG_IDX_W'(1);
                    if (!miss_q && (dec_q == label_q)) begin
                        hits_d = hits_q + IMG_IDX_W'(1);
                    end
                end
                if ((CNT1_W'(total_q) + CNT1_W'(1)) >= CNT1_W'(num_q)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_FLUSH;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = is_busy(state_d);
        done_d = (state_d == ST_DONE);
        pipe_d = (state_d != ST_FLUSH);
    end

    // FSM state and control/result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            flush_cnt_q <= '0;
            wait_cnt_q  <= '0;
            num_q       <= '0;
            img_idx_q   <= '0;
            hits_q      <= '0;
            total_q     <= '0;
            label_q     <= '0;
            dec_q       <= '0;
            miss_q      <= 1'b0;
            tmo_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pipe_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            num_q       <= num_d;
            img_idx_q   <= img_idx_d;
            hits_q      <= hits_d;
            total_q     <= total_d;
            label_q     <= label_d;
            dec_q       <= dec_d;
            miss_q      <= miss_d;
            tmo_q       <= tmo_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pipe_q      <= pipe_d;
        end
    end

    // Pixel pipeline matching the one-cycle store latency plus the output register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_vld_q   <= 1'b0;
            rd_last_q  <= 1'b0;
            pix_vld_q  <= 1'b0;
            pix_last_q <= 1'b0;
            pix_q      <= '0;
        end else begin
            rd_vld_q   <= issue_c;
            rd_last_q  <= last_c;
            pix_vld_q  <= rd_vld_q;
            pix_last_q <= rd_last_q;
            pix_q      <= rd_vld_q ? rd_data : '0;
        end
    end

endmodule

// File: tb/tb_image_sequencer.sv
// Scoreboard bench for image_sequencer: store models, decision driver, scenario tasks.
module tb_image_sequencer;

    localparam int NPIX = 784;
    localparam int TMO  = 4095;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  num_images = '0;
    logic [19:0] rd_addr;
    logic [7:0]  rd_data;
    logic [9:0]  lbl_addr;
    logic [3:0]  lbl_data;
    logic [7:0]  pix_out;
    logic        pix_valid;
    logic        pipe_rst_n;
    logic [3:0]  decision;
    logic        decision_valid;
    logic [9:0]  hits;
    logic [9:0]  total;
    logic        busy;
    logic        done;
    logic        timeout_err;

    image_sequencer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .num_images     (num_images),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .lbl_addr       (lbl_addr),
        .lbl_data       (lbl_data),
        .pix_out        (pix_out),
        .pix_valid      (pix_valid),
        .pipe_rst_n     (pipe_rst_n),
        .decision       (decision),
        .decision_valid (decision_valid),
        .hits           (hits),
        .total          (total),
        .busy           (busy),
        .done           (done),
        .timeout_err    (timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [7:0]  exp_pix[$];
    logic [7:0]  obs_pix[$];
    int          vrun_q[$];
    int          flush_q[$];
    int          gap_q[$];
    logic [19:0] base_q[$];
    int          done_cnt = 0;
    int          cyc = 0;
    int          vrun = 0;
    int          lowrun = 0;
    int          last_pv = 0;

    logic [3:0] lbl_mem[16];
    logic [3:0] dec_tab[16];
    bit         dec_en[16];
    bit         noise_en = 1'b0;

    // Pixel store content: image i, pixel k holds (k + 3*i) mod 256.
    function automatic logic [7:0] pix_model(input int a);
        return 8'((a % NPIX) + 3 * (a / NPIX));
    endfunction

    // Synchronous stores with one-cycle read latency.
    always @(posedge clk) begin
        rd_data  <= pix_model(int'(rd_addr));
        lbl_data <= lbl_mem[lbl_addr[3:0]];
    end

    // Output monitor: records pixels, valid bursts, flush lengths, stream bases, done cycles.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (pix_valid === 1'b1) begin
            obs_pix.push_back(pix_out);
            vrun = vrun + 1;
            last_pv = cyc;
        end else if (vrun != 0) begin
            vrun_q.push_back(vrun);
            vrun = 0;
        end
        if (busy === 1'b1 && pipe_rst_n === 1'b0) begin
            if (lowrun == 0) gap_q.push_back(cyc - last_pv);
            lowrun = lowrun + 1;
        end else if (lowrun != 0) begin
            flush_q.push_back(lowrun);
            base_q.push_back(rd_addr);
            lowrun = 0;
        end
        if (done === 1'b1) done_cnt = done_cnt + 1;
    end

    // Classifier stand-in: answers a few cycles into WAIT, optionally injects a stray pulse in STREAM.
    initial begin : decision_driver
        int  img;
        bit  pv_prev;
        img = 0;
        pv_prev = 1'b0;
        decision = '0;
        decision_valid = 1'b0;
        forever begin
            @(negedge clk);
            decision_valid = 1'b0;
            if (busy !== 1'b1) img = 0;
            if (noise_en && pix_valid === 1'b1 && !pv_prev) begin
                decision = 4'hF;
                decision_valid = 1'b1;
            end
            if (pv_prev && pix_valid === 1'b0 && busy === 1'b1) begin
                if (dec_en[img[3:0]]) begin
                    repeat (2) @(negedge clk);
                    decision = dec_tab[img[3:0]];
                    decision_valid = 1'b1;
                end
                img = img + 1;
            end
            pv_prev = (pix_valid === 1'b1);
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_sb();
        exp_pix.delete(); obs_pix.delete(); vrun_q.delete();
        flush_q.delete(); gap_q.delete(); base_q.delete();
    endtask

    task automatic run_start(input int n);
        @(negedge clk);
        start = 1'b1;
        num_images = 10'(n);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok, output int used);
        ok = 1'b0;
        used = 0;
        while (used < budget) begin
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            used++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if ({pix_valid, pipe_rst_n, busy, done, timeout_err} !== 5'b0) begin failures++; $display("FAIL reset_flags got=%b exp=00000", {pix_valid, pipe_rst_n, busy, done, timeout_err}); end
        checks++; if (pix_out !== 8'd0) begin failures++; $display("FAIL reset_pix_out got=%0d exp=0", pix_out); end
        checks++; if (rd_addr !== 20'd0) begin failures++; $display("FAIL reset_rd_addr got=%0d exp=0", rd_addr); end
        checks++; if (lbl_addr !== 10'd0) begin failures++; $display("FAIL reset_lbl_addr got=%0d exp=0", lbl_addr); end
        checks++; if (hits !== 10'd0 || total !== 10'd0) begin failures++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", hits, total); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (pipe_rst_n !== 1'b1) begin failures++; $display("FAIL reset_release_pipe got=%b exp=1", pipe_rst_n); end
    endtask

    task automatic test_zero_images();
        bit ok; int used; int d0;
        clear_sb();
        d0 = done_cnt;
        run_start(0);
        wait_done(3, ok, used);
        checks++; if (ok !== 1'b1 || used > 1) begin failures++; $display("FAIL zero_done got_ok=%b cycles=%0d exp=1 within 1", ok, used); end
        repeat (3) @(negedge clk);
        checks++; if (done_cnt - d0 != 1) begin failures++; $display("FAIL zero_done_pulses got=%0d exp=1", done_cnt - d0); end
        checks++; if (obs_pix.size() != 0) begin failures++; $display("FAIL zero_pix_valid got=%0d exp=0", obs_pix.size()); end
        checks++; if (hits !== 10'd0 || total !== 10'd0) begin failures++; $display("FAIL zero_counts got=%0d/%0d exp=0/0", hits, total); end
        run_start(1001);
        wait_done(3, ok, used);
        checks++; if (ok !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL over_max_done got_ok=%b busy=%b exp=1/0", ok, busy); end
        repeat (3) @(negedge clk);
        checks++; if (obs_pix.size() != 0 || total !== 10'd0) begin failures++; $display("FAIL over_max_idle got_pix=%0d total=%0d exp=0/0", obs_pix.size(), total); end
    endtask

    task automatic test_single_ramp();
        bit ok; int used; int d0; int n; logic [7:0] e; logic [7:0] o;
        clear_sb();
        lbl_mem[0] = 4'd7; dec_tab[0] = 4'd7; dec_en[0] = 1'b1;
        for (int k = 0; k < NPIX; k++) exp_pix.push_back(8'(k % 256));
        d0 = done_cnt;
        run_start(1);
        wait_done(20000, ok, used);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL ramp_done_timeout waited=%0d", used); end
        checks++; if (hits !== 10'd1 || total !== 10'd1) begin failures++; $display("FAIL ramp_counts got=%0d/%0d exp=1/1", hits, total); end
        checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL ramp_timeout_err got=%b exp=0", timeout_err); end
        repeat (3) @(negedge clk);
        checks++; if (done_cnt - d0 != 1) begin failures++; $display("FAIL ramp_done_pulses got=%0d exp=1", done_cnt - d0); end
        checks++; if (obs_pix.size() != NPIX) begin failures++; $display("FAIL ramp_pix_count got=%0d exp=%0d", obs_pix.size(), NPIX); end
        n = 0;
        while (exp_pix.size() > 0 && obs_pix.size() > 0) begin
            e = exp_pix.pop_front(); o = obs_pix.pop_front();
            checks++; if (o !== e) begin failures++; $display("FAIL ramp_pixel idx=%0d got=%0d exp=%0d", n, o, e); end
            n++;
        end
        checks++; if (vrun_q.size() != 1 || vrun_q[0] != NPIX) begin failures++; $display("FAIL ramp_valid_run got_runs=%0d first=%0d exp=1/%0d", vrun_q.size(), (vrun_q.size() > 0) ? vrun_q[0] : -1, NPIX); end
        checks++; if (flush_q.size() != 1 || flush_q[0] != 2) begin failures++; $display("FAIL ramp_flush got_n=%0d len=%0d exp=1/2", flush_q.size(), (flush_q.size() > 0) ? flush_q[0] : -1); end
        checks++; if (base_q.size() != 1 || base_q[0] !== 20'd0) begin failures++; $display("FAIL ramp_base got_n=%0d base=%0d exp=1/0", base_q.size(), (base_q.size() > 0) ? base_q[0] : 20'hFFFFF); end
    endtask

    task automatic test_three_images();
        bit ok; int used; int n; logic [7:0] e; logic [7:0] o; int f; logic [19:0] b;
        clear_sb();
        lbl_mem[0] = 4'd1; lbl_mem[1] = 4'd2; lbl_mem[2] = 4'd3;
        dec_tab[0] = 4'd1; dec_tab[1] = 4'd5; dec_tab[2] = 4'd3;
        dec_en[0] = 1'b1; dec_en[1] = 1'b1; dec_en[2] = 1'b1;
        for (int i = 0; i < 3; i++)
            for (int k = 0; k < NPIX; k++) exp_pix.push_back(pix_model(i * NPIX + k));
        run_start(3);
        wait_done(20000, ok, used);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL three_done_timeout waited=%0d", used); end
        checks++; if (hits !== 10'd2 || total !== 10'd3) begin failures++; $display("FAIL three_counts got=%0d/%0d exp=2/3", hits, total); end
        repeat (3) @(negedge clk);
        checks++; if (obs_pix.size() != 3 * NPIX) begin failures++; $display("FAIL three_pix_count got=%0d exp=%0d", obs_pix.size(), 3 * NPIX); end
        n = 0;
        while (exp_pix.size() > 0 && obs_pix.size() > 0) begin
            e = exp_pix.pop_front(); o = obs_pix.pop_front();
            checks++; if (o !== e) begin failures++; $display("FAIL three_pixel idx=%0d got=%0d exp=%0d", n, o, e); end
            n++;
        end
        for (int i = 0; i < 3; i++) begin
            f = (flush_q.size() > 0) ? flush_q.pop_front() : -1;
            b = (base_q.size() > 0) ? base_q.pop_front() : 20'hFFFFF;
            checks++; if (f != 2) begin failures++; $display("FAIL three_flush img=%0d got=%0d exp=2", i, f); end
            checks++; if (b !== 20'(i * NPIX)) begin failures++; $display("FAIL three_base img=%0d got=%0d exp=%0d", i, b, i * NPIX); end
        end
        checks++; if (vrun_q.size() != 3 || vrun_q[2] != NPIX) begin failures++; $display("FAIL three_valid_runs got=%0d exp=3", vrun_q.size()); end
    endtask

    task automatic test_timeout();
        bit ok; int used; int n; logic [7:0] e; logic [7:0] o; int g;
        clear_sb();
        lbl_mem[0] = 4'd5; lbl_mem[1] = 4'd6;
        dec_en[0] = 1'b0; dec_en[1] = 1'b1; dec_tab[1] = 4'd6;
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < NPIX; k++) exp_pix.push_back(pix_model(i * NPIX + k));
        run_start(2);
        wait_done(20000, ok, used);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL tmo_done_timeout waited=%0d", used); end
        checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL tmo_flag got=%b exp=1", timeout_err); end
        checks++; if (hits !== 10'd1 || total !== 10'd2) begin failures++; $display("FAIL tmo_counts got=%0d/%0d exp=1/2", hits, total); end
        g = (gap_q.size() > 1) ? gap_q[1] : -1;
        checks++; if (g < TMO + 1 || g > TMO + 3) begin failures++; $display("FAIL tmo_wait_len got=%0d exp=%0d..%0d", g, TMO + 1, TMO + 3); end
        repeat (3) @(negedge clk);
        n = 0;
        checks++; if (obs_pix.size() != 2 * NPIX) begin failures++; $display("FAIL tmo_pix_count got=%0d exp=%0d", obs_pix.size(), 2 * NPIX); end
        while (exp_pix.size() > 0 && obs_pix.size() > 0) begin
            e = exp_pix.pop_front(); o = obs_pix.pop_front();
            checks++; if (o !== e) begin failures++; $display("FAIL tmo_pixel idx=%0d got=%0d exp=%0d", n, o, e); end
            n++;
        end
        dec_en[0] = 1'b1;
    endtask

    task automatic test_busy_ignore();
        bit ok; int used; int d0; int n; logic [7:0] e; logic [7:0] o;
        clear_sb();
        lbl_mem[0] = 4'd4; lbl_mem[1] = 4'd9;
        dec_tab[0] = 4'd4; dec_tab[1] = 4'd9; dec_en[0] = 1'b1; dec_en[1] = 1'b1;
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < NPIX; k++) exp_pix.push_back(pix_model(i * NPIX + k));
        noise_en = 1'b1;
        d0 = done_cnt;
        run_start(2);
        repeat (100) @(negedge clk);
        start = 1'b1; num_images = 10'd1;
        @(negedge clk);
        start = 1'b0;
        wait_done(20000, ok, used);
        noise_en = 1'b0;
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL busy_done_timeout waited=%0d", used); end
        checks++; if (hits !== 10'd2 || total !== 10'd2) begin failures++; $display("FAIL busy_counts got=%0d/%0d exp=2/2", hits, total); end
        checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL busy_tmo_cleared got=%b exp=0", timeout_err); end
        repeat (3) @(negedge clk);
        checks++; if (done_cnt - d0 != 1) begin failures++; $display("FAIL busy_done_pulses got=%0d exp=1", done_cnt - d0); end
        checks++; if (obs_pix.size() != 2 * NPIX) begin failures++; $display("FAIL busy_pix_count got=%0d exp=%0d", obs_pix.size(), 2 * NPIX); end
        n = 0;
        while (exp_pix.size() > 0 && obs_pix.size() > 0) begin
            e = exp_pix.pop_front(); o = obs_pix.pop_front();
            checks++; if (o !== e) begin failures++; $display("FAIL busy_pixel idx=%0d got=%0d exp=%0d", n, o, e); end
            n++;
        end
    endtask

    task automatic test_reset_midrun();
        bit ok; int used; int d0; int n; logic [7:0] e; logic [7:0] o;
        clear_sb();
        lbl_mem[0] = 4'd1; lbl_mem[1] = 4'd2; lbl_mem[2] = 4'd3;
        dec_tab[0] = 4'd1; dec_tab[1] = 4'd2; dec_tab[2] = 4'd3;
        dec_en[0] = 1'b1; dec_en[1] = 1'b1; dec_en[2] = 1'b1;
        run_start(3);
        used = 0;
        while (obs_pix.size() < NPIX + 400 && used < 10000) begin
            @(negedge clk);
            used++;
        end
        checks++; if (obs_pix.size() < NPIX + 400) begin failures++; $display("FAIL midrun_reach_pixel got=%0d exp>=%0d", obs_pix.size(), NPIX + 400); end
        d0 = done_cnt;
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if ({pix_valid, pipe_rst_n, busy, done, timeout_err} !== 5'b0) begin failures++; $display("FAIL midrun_reset_flags got=%b exp=00000", {pix_valid, pipe_rst_n, busy, done, timeout_err}); end
        checks++; if (pix_out !== 8'd0 || rd_addr !== 20'd0 || lbl_addr !== 10'd0) begin failures++; $display("FAIL midrun_reset_bus got=%0d/%0d/%0d exp=0/0/0", pix_out, rd_addr, lbl_addr); end
        checks++; if (hits !== 10'd0 || total !== 10'd0) begin failures++; $display("FAIL midrun_reset_counts got=%0d/%0d exp=0/0", hits, total); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (pipe_rst_n !== 1'b1) begin failures++; $display("FAIL midrun_pipe_release got=%b exp=1", pipe_rst_n); end
        repeat (20) @(negedge clk);
        checks++; if (done_cnt != d0 || busy !== 1'b0) begin failures++; $display("FAIL midrun_no_done got_pulses=%0d busy=%b exp=0/0", done_cnt - d0, busy); end
        clear_sb();
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < NPIX; k++) exp_pix.push_back(pix_model(i * NPIX + k));
        run_start(2);
        wait_done(20000, ok, used);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL midrun_rerun_timeout waited=%0d", used); end
        checks++; if (hits !== 10'd2 || total !== 10'd2) begin failures++; $display("FAIL midrun_rerun_counts got=%0d/%0d exp=2/2", hits, total); end
        repeat (3) @(negedge clk);
        checks++; if (obs_pix.size() != 2 * NPIX) begin failures++; $display("FAIL midrun_pix_count got=%0d exp=%0d", obs_pix.size(), 2 * NPIX); end
        n = 0;
        while (exp_pix.size() > 0 && obs_pix.size() > 0) begin
            e = exp_pix.pop_front(); o = obs_pix.pop_front();
            checks++; if (o !== e) begin failures++; $display("FAIL midrun_pixel idx=%0d got=%0d exp=%0d", n, o, e); end
            n++;
        end
    endtask

    initial begin : main
        for (int i = 0; i < 16; i++) begin
            lbl_mem[i] = '0;
            dec_tab[i] = '0;
            dec_en[i]  = 1'b1;
        end
        test_reset();
        test_zero_images();
        test_single_ramp();
        test_three_images();
        test_timeout();
        test_busy_ignore();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
